// File: rtl/min_max_ctrl.sv
// Min/max range controller: button editing of min, max and value,
// auto-sweep of value across the range, and an LED blink oscillator.
module min_max_ctrl #(
  parameter int VALSIZE = 4,
  parameter int OSC_DIV = 4,
  parameter int STEP    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         com_sel_i,
  input  logic               sel_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               sweep_i,
  output logic [1:0]         com_o,
  output logic [VALSIZE-1:0] min_o,
  output logic [VALSIZE-1:0] max_o,
  output logic [VALSIZE-1:0] val_o,
  output logic               osc_o,
  output logic [1:0]         edit_o,
  output logic               sweeping_o
);

  localparam int OW = $clog2(OSC_DIV + 1);
  localparam int SW = $clog2(STEP + 1);
  localparam logic [VALSIZE-1:0] VTOP = '1;
  localparam logic [1:0] E_MIN = 2'b00;
  localparam logic [1:0] E_MAX = 2'b01;
  localparam logic [1:0] E_VAL = 2'b10;

  typedef enum logic {EDIT, SWEEP} state_t;

  state_t        state;
  logic          sel_q, inc_q, dec_q;
  logic [OW-1:0] osc_cnt;
  logic [SW-1:0] step_cnt;

  logic sel_e, up, dn, go;

  assign sel_e = sel_i & ~sel_q;
  assign up    = inc_i & ~inc_q & ~(dec_i & ~dec_q);
  assign dn    = dec_i & ~dec_q & ~(inc_i & ~inc_q);
  assign go    = sweep_i && (com_sel_i == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= EDIT;
      com_o      <= 2'b10;
      min_o      <= '0;
      max_o      <= VTOP;
      val_o      <= '0;
      osc_o      <= 1'b0;
      edit_o     <= E_MIN;
      sweeping_o <= 1'b0;
      sel_q      <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      osc_cnt    <= '0;
      step_cnt   <= '0;
    end else begin
      com_o <= com_sel_i;
      sel_q <= sel_i;
      inc_q <= inc_i;
      dec_q <= dec_i;

      if (osc_cnt == OW'(OSC_DIV - 1)) begin
        osc_cnt <= '0;
        osc_o   <= ~osc_o;
      end else begin
        osc_cnt <= osc_cnt + 1'b1;
      end

      unique case (state)
        EDIT: begin
          if (go) begin
            state      <= SWEEP;
            sweeping_o <= 1'b1;
            val_o      <= min_o;
            step_cnt   <= '0;
          end else if (sel_e) begin
            unique case (edit_o)
              E_MIN:   edit_o <= E_MAX;
              E_MAX:   edit_o <= E_VAL;
              default: edit_o <= E_MIN;
            endcase
          end else begin
            // min never passes max and max never drops below min
            unique case (edit_o)
              E_MIN: begin
                if (up && min_o != max_o)
                  min_o <= min_o + 1'b1;
                else if (dn && min_o != '0)
                  min_o <= min_o - 1'b1;
              end
              E_MAX: begin
                if (up && max_o != VTOP)
                  max_o <= max_o + 1'b1;
                else if (dn && max_o != min_o)
                  max_o <= max_o - 1'b1;
              end
              E_VAL: begin
                if (up && val_o != VTOP)
                  val_o <= val_o + 1'b1;
                else if (dn && val_o != '0)
                  val_o <= val_o - 1'b1;
              end
              default: edit_o <= E_MIN;
            endcase
          end
        end
        SWEEP: begin
          if (!go) begin
            state      <= EDIT;
            sweeping_o <= 1'b0;
          end else if (step_cnt == SW'(STEP - 1)) begin
            step_cnt <= '0;
            val_o    <= (val_o >= max_o) ? min_o : val_o + 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule
